// File: rtl/stevej_watchdog_kicker.sv
// TinyQV bus initiator: programs the watchdog windows, enables it, then pats it periodically.
// Define KICKER_READBACK_EN to read both window registers back and verify them before enabling.
module stevej_watchdog_kicker #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] win_start,
  input  logic [CNT_W-1:0] win_close,
  input  logic [CNT_W-1:0] pat_at,
  input  logic             wdt_irq,
  output logic [5:0]       address,
  output logic [31:0]      data_out,
  output logic [1:0]       data_write_n,
  output logic [1:0]       data_read_n,
  input  logic [31:0]      data_in,
  input  logic             data_ready,
  output logic             running,
  output logic [15:0]      pat_count,
  output logic             missed,
  output logic             cfg_error,
  output logic             bus_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    IDLE, WR_WS, WR_WC, WR_EN, WAIT, WR_PAT, WR_DIS
`ifdef KICKER_READBACK_EN
    , RD_WS, RD_WC
`endif
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] ws_q, wc_q, pa_q, cnt;
  logic [TW-1:0]    timer;
  logic             pend;
  logic             bus_act, accept, tmo, halt, cfg_ok, start_ok, in_bus;
  logic             issue, req_rd;
  logic [5:0]       req_addr;
  logic [31:0]      req_data;

  assign bus_act  = (data_write_n == 2'b10) || (data_read_n == 2'b10);
  assign accept   = bus_act && data_ready;
  assign tmo      = bus_act && !data_ready && (timer == TW'(TIMEOUT - 1));
  assign halt     = stop || (wdt_irq && running);
  assign cfg_ok   = (win_start < win_close) && (win_start < pat_at) && (pat_at < win_close);
  assign start_ok = (state == IDLE) && start && !stop && cfg_ok;
  assign in_bus   = (state != IDLE) && (state != WAIT);

`ifdef KICKER_READBACK_EN
  logic rd_bad_q, rd_mis;
  assign rd_mis = rd_bad_q || (data_in != 32'(wc_q));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    issue    = 1'b0;
    req_rd   = 1'b0;
    req_addr = 6'd0;
    req_data = 32'd0;
    case (state)
      WR_WS:  begin req_addr = 6'd1; req_data = 32'(ws_q); end
      WR_WC:  begin req_addr = 6'd2; req_data = 32'(wc_q); end
      WR_EN:  req_data = 32'd1;
      WR_PAT: req_addr = 6'd3;
`ifdef KICKER_READBACK_EN
      RD_WS:  begin req_addr = 6'd1; req_rd = 1'b1; end
      RD_WC:  begin req_addr = 6'd2; req_rd = 1'b1; end
`endif
      default: ;
    endcase
    case (state)
      IDLE: if (start_ok) state_d = WR_WS;
      // an interrupt or stop outranks a due PAT
      WAIT: begin
        if (halt)             state_d = WR_DIS;
        else if (cnt == pa_q) state_d = WR_PAT;
      end
      default: begin
        issue = !bus_act;
        if (tmo) state_d = IDLE;
        else if (accept) begin
          if (state == WR_DIS) state_d = IDLE;
`ifdef KICKER_READBACK_EN
          else if (state == RD_WC && rd_mis) state_d = IDLE;
`endif
          else if (halt || pend) state_d = WR_DIS;
          else begin
            case (state)
              WR_WS: state_d = WR_WC;
`ifdef KICKER_READBACK_EN
              WR_WC: state_d = RD_WS;
              RD_WS: state_d = RD_WC;
              RD_WC: state_d = WR_EN;
`else
              WR_WC: state_d = WR_EN;
`endif
              default: state_d = WAIT;
            endcase
          end
        end
      end
    endcase
  end

  // Bus request registers: an accept always leaves one idle cycle before the next issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address      <= '0;
      data_out     <= '0;
      data_write_n <= 2'b11;
      timer        <= '0;
    end else if (issue) begin
      address  <= req_addr;
      data_out <= req_data;
      timer    <= '0;
      if (!req_rd) data_write_n <= 2'b10;
    end else if (accept || tmo) begin
      data_write_n <= 2'b11;
    end else if (bus_act) begin
      timer <= timer + 1'b1;
    end
  end

`ifdef KICKER_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_read_n <= 2'b11;
      rd_bad_q    <= 1'b0;
    end else begin
      if (issue && req_rd)    data_read_n <= 2'b10;
      else if (accept || tmo) data_read_n <= 2'b11;
      if (accept && state == RD_WS) rd_bad_q <= (data_in != 32'(ws_q));
    end
  end
`else
  logic unused_data_in;
  assign unused_data_in = ^data_in;
  assign data_read_n    = 2'b11;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_q      <= '0;
      wc_q      <= '0;
      pa_q      <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      running   <= 1'b0;
      pat_count <= '0;
      missed    <= 1'b0;
      cfg_error <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if (start_ok) begin
        ws_q      <= win_start;
        wc_q      <= win_close;
        pa_q      <= pat_at;
        pat_count <= '0;
        missed    <= 1'b0;
        cfg_error <= 1'b0;
        bus_err   <= 1'b0;
      end else begin
        if (state == IDLE && start && !stop) cfg_error <= 1'b1;
`ifdef KICKER_READBACK_EN
        if (accept && state == RD_WC && rd_mis) cfg_error <= 1'b1;
`endif
        if (wdt_irq && running) missed <= 1'b1;
        if (tmo) bus_err <= 1'b1;
        if (accept && state == WR_PAT && pat_count != 16'hFFFF) pat_count <= pat_count + 1'b1;
      end
      if (tmo || (accept && state == WR_DIS)) running <= 1'b0;
      else if (accept && state == WR_EN)      running <= 1'b1;
      if (state != WAIT && state_d == WAIT) cnt <= '0;
      else if (state == WAIT)               cnt <= cnt + 1'b1;
      // stop/interrupt seen mid-transaction is held until that transaction resolves
      if (!in_bus || state == WR_DIS || accept || tmo) pend <= 1'b0;
      else if (halt)                                  pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stevej_watchdog_kicker.sv
// Bench for stevej_watchdog_kicker: queue-based job model checked every cycle, plus directed scenarios.
module tb_stevej_watchdog_kicker;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 32;
  localparam int K_WS = 0, K_WC = 1, K_EN = 2, K_PAT = 3, K_DIS = 4;
  localparam int M_IDLE = 0, M_BUS = 1, M_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, wdt_irq = 1'b0, data_ready = 1'b0;
  logic [31:0] win_start = '0, win_close = '0, pat_at = '0, data_in = '0;
  logic [5:0]  address;
  logic [31:0] data_out;
  logic [1:0]  data_write_n, data_read_n;
  logic        running, missed, cfg_error, bus_err;
  logic [15:0] pat_count;

  int total = 0, bad = 0, cyc = 0;
  bit chk_en = 1'b0;

  stevej_watchdog_kicker #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .win_start(win_start), .win_close(win_close), .pat_at(pat_at), .wdt_irq(wdt_irq),
    .address(address), .data_out(data_out), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_in(data_in), .data_ready(data_ready), .running(running), .pat_count(pat_count),
    .missed(missed), .cfg_error(cfg_error), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: a queue of pending bus jobs plus a countdown to the next PAT
  int          q[$];
  int          cur = 0, mode = M_IDLE, tcnt = 0;
  longint      cd = 0;
  bit          halt_p = 0, dis_seq = 0;
  logic [1:0]  m_wn = 2'b11;
  logic [5:0]  m_addr = '0;
  logic [31:0] m_data = '0, l_ws = '0, l_wc = '0, l_pa = '0;
  bit          m_run = 0, m_missed = 0, m_cfg = 0, m_berr = 0;
  int          m_pc = 0;
  bit          m_act, m_acc, m_to, m_hev, m_run0;

  task automatic model_step();
    if (rst) begin
      q.delete(); mode = M_IDLE; halt_p = 0; dis_seq = 0; tcnt = 0; cd = 0;
      m_wn = 2'b11; m_addr = '0; m_data = '0;
      m_run = 0; m_missed = 0; m_cfg = 0; m_berr = 0; m_pc = 0;
      return;
    end
    m_act  = (m_wn == 2'b10);
    m_acc  = m_act && data_ready;
    m_to   = m_act && !data_ready && (tcnt == TIMEOUT - 1);
    m_run0 = m_run;
    m_hev  = stop || (wdt_irq && m_run0);
    if (wdt_irq && m_run0) m_missed = 1;
    case (mode)
      M_IDLE: if (start && !stop) begin
        if (win_start < win_close && win_start < pat_at && pat_at < win_close) begin
          l_ws = win_start; l_wc = win_close; l_pa = pat_at;
          m_pc = 0; m_missed = 0; m_cfg = 0; m_berr = 0;
          q.delete(); q.push_back(K_WS); q.push_back(K_WC); q.push_back(K_EN);
          mode = M_BUS; halt_p = 0; dis_seq = 0;
        end else m_cfg = 1;
      end
      M_WAIT: begin
        if (m_hev) begin q.push_back(K_DIS); dis_seq = 1; mode = M_BUS; end
        else begin
          cd--;
          if (cd == 0) begin q.push_back(K_PAT); mode = M_BUS; end
        end
      end
      default: begin
        if (m_acc) begin
          m_wn = 2'b11;
          if (cur == K_DIS) begin m_run = 0; mode = M_IDLE; dis_seq = 0; end
          else begin
            if (cur == K_EN) m_run = 1;
            if (cur == K_PAT && m_pc < 65535) m_pc++;
            if (halt_p || m_hev) begin q.delete(); q.push_back(K_DIS); dis_seq = 1; end
            else if (cur == K_EN || cur == K_PAT) begin mode = M_WAIT; cd = longint'(l_pa) + 1; end
          end
          halt_p = 0;
        end else if (m_to) begin
          m_wn = 2'b11; m_berr = 1; m_run = 0; q.delete();
          mode = M_IDLE; halt_p = 0; dis_seq = 0;
        end else begin
          if (m_hev && !dis_seq) halt_p = 1;
          if (m_act) tcnt++;
          else if (q.size() > 0) begin
            cur = q.pop_front(); m_wn = 2'b10; tcnt = 0;
            case (cur)
              K_WS:    begin m_addr = 6'd1; m_data = l_ws; end
              K_WC:    begin m_addr = 6'd2; m_data = l_wc; end
              K_EN:    begin m_addr = 6'd0; m_data = 32'd1; end
              K_PAT:   begin m_addr = 6'd3; m_data = 32'd0; end
              default: begin m_addr = 6'd0; m_data = 32'd0; end
            endcase
          end
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (clk) cyc++;
    model_step();
  end

  // ---------------- accepted-write log and per-cycle compare
  int          lg_cyc[$];
  logic [5:0]  lg_addr[$];
  logic [31:0] lg_data[$];

  initial forever begin
    @(negedge clk);
    if (data_write_n == 2'b10 && data_ready) begin
      lg_cyc.push_back(cyc); lg_addr.push_back(address); lg_data.push_back(data_out);
    end
    if (chk_en) begin
      check("write_n", 32'(data_write_n), 32'(m_wn));
      check("read_n", 32'(data_read_n), 32'h3);
      check("running", 32'(running), 32'(m_run));
      check("pat_count", 32'(pat_count), 32'(m_pc));
      check("missed", 32'(missed), 32'(m_missed));
      check("cfg_error", 32'(cfg_error), 32'(m_cfg));
      check("bus_err", 32'(bus_err), 32'(m_berr));
      if (m_wn == 2'b10) begin
        check("address", 32'(address), 32'(m_addr));
        check("data_out", data_out, m_data);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_start(input int ws, input int wc, input int pa);
    win_start = 32'(ws); win_close = 32'(wc); pat_at = 32'(pa);
    start = 1'b1; tick(); start = 1'b0;
  endtask

  function automatic int n_pat();
    int n = 0;
    foreach (lg_addr[i]) if (lg_addr[i] == 6'd3) n++;
    return n;
  endfunction

  task automatic log_at(input string name, input int idx, input int a, input int d);
    if (idx < 0 || idx >= lg_addr.size()) check({name, "_present"}, 32'(lg_addr.size()), 32'(idx + 1));
    else begin
      check({name, "_addr"}, 32'(lg_addr[idx]), 32'(a));
      check({name, "_data"}, lg_data[idx], 32'(d));
    end
  endtask

  int pidx[$];
  int nlog, dr, nact;
  bit ok;

  initial begin
    // reset values
    @(posedge clk); #2;
    check("rst_write_n", 32'(data_write_n), 32'h3);
    check("rst_address", 32'(address), 32'h0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_status", {running, missed, cfg_error, bus_err, pat_count}, 32'h0);
    tick(); rst = 1'b0; chk_en = 1'b1;

    // valid sequence and steady state
    data_ready = 1'b1;
    lg_cyc.delete(); lg_addr.delete(); lg_data.delete();
    do_start(10, 100, 50);
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin tick(); ok = (n_pat() >= 5); end
    check("wait_pat5", 32'(ok), 32'h1);
    log_at("ws_write", 0, 1, 10);
    log_at("wc_write", 1, 2, 100);
    log_at("en_write", 2, 0, 1);
    if (lg_cyc.size() >= 8) begin
      check("gap_ws_wc", 32'(lg_cyc[1] - lg_cyc[0]), 32'd2);
      check("gap_wc_en", 32'(lg_cyc[2] - lg_cyc[1]), 32'd2);
      for (int i = 3; i < 8; i++) begin
        check("pat_addr", 32'(lg_addr[i]), 32'd3);
        check("pat_spacing", 32'(lg_cyc[i] - lg_cyc[i-1]), 32'd53);
      end
    end else check("log_len", 32'(lg_cyc.size()), 32'd8);
    check("pat_count_5", 32'(pat_count), 32'd5);
    check("model_pc_5", 32'(m_pc), 32'd5);
    check("missed_0", 32'(missed), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = !running; end
    check("stop_idle", 32'(ok), 32'h1);
    log_at("dis_write", lg_addr.size() - 1, 0, 0);

    // invalid config: pat_at below win_start
    nlog = lg_addr.size();
    do_start(10, 100, 5);
    tick(5);
    check("bad_cfg_error", 32'(cfg_error), 32'h1);
    check("bad_cfg_nowrite", 32'(lg_addr.size()), 32'(nlog));
    check("bad_cfg_running", 32'(running), 32'h0);

    // stop while a PAT is stalled on the bus
    do_start(2, 20, 5);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = running; end
    check("run_up", 32'(ok), 32'h1);
    data_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin tick(); ok = (data_write_n == 2'b10 && address == 6'd3); end
    check("pat_stalled", 32'(ok), 32'h1);
    stop = 1'b1; tick(); stop = 1'b0; data_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin tick(); ok = !running; end
    check("midpat_stop_idle", 32'(ok), 32'h1);
    log_at("midpat_pat", lg_addr.size() - 2, 3, 0);
    log_at("midpat_dis", lg_addr.size() - 1, 0, 0);
    check("midpat_pc", 32'(pat_count), 32'd1);

    // timeout: no responder
    data_ready = 1'b0;
    do_start(2, 20, 5);
    nact = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (data_write_n == 2'b10) nact++; end
    check("tmo_active_cycles", 32'(nact), 32'd15);
    check("tmo_bus_err", 32'(bus_err), 32'h1);
    check("tmo_write_n", 32'(data_write_n), 32'h3);
    check("tmo_running", 32'(running), 32'h0);

    // missed window
    data_ready = 1'b1;
    do_start(2, 20, 10);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = running; end
    tick(3);
    wdt_irq = 1'b1; tick(); wdt_irq = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = !running; end
    check("miss_idle", 32'(ok), 32'h1);
    tick(40);
    check("miss_flag", 32'(missed), 32'h1);
    check("miss_no_pat", 32'(pat_count), 32'h0);
    log_at("miss_dis", lg_addr.size() - 1, 0, 0);
    do_start(2, 20, 10);
    tick();
    check("miss_cleared", 32'(missed), 32'h0);

    // async reset in the middle of a write
    data_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin tick(); ok = (data_write_n == 2'b10); end
    check("mid_active", 32'(ok), 32'h1);
    #1 rst = 1'b1; #1;
    check("arst_write_n", 32'(data_write_n), 32'h3);
    check("arst_addr_data", 32'(address) | data_out, 32'h0);
    check("arst_running", 32'(running), 32'h0);
    tick(); rst = 1'b0;

    // randomized traffic
    dr = 0;
    for (int i = 0; i < 15000; i++) begin
      if (dr > 0) begin data_ready = 1'b0; dr--; end
      else begin
        data_ready = ($urandom_range(0, 9) < 8);
        if ($urandom_range(0, 999) == 0) dr = 20;
      end
      start     = ($urandom_range(0, 39) == 0);
      stop      = ($urandom_range(0, 199) == 0);
      wdt_irq   = ($urandom_range(0, 299) == 0);
      win_start = $urandom_range(0, 12);
      win_close = $urandom_range(0, 40);
      pat_at    = $urandom_range(0, 40);
      data_in   = $urandom;
      tick();
    end
    start = 0; stop = 0; wdt_irq = 0; data_ready = 1'b1;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
